// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states and
// a helper that turns a size code into a byte count.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the request/response handshake from the datapath and the
// Data_Memory port; the unit is the slave of requests and drives the memory.
interface lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  size_e       req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, Read_Data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output Mem_Addr, Write_Data, MemWrite, MemRead
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, Read_Data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  Mem_Addr, Write_Data, MemWrite, MemRead
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Selects the low 8<<size bits of a dword and sign- or zero-extends them to
// 64 bits; feeding all-ones with zero extension yields a byte-lane mask.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] rbuf_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [63:0] rdata_o
);

  always_comb begin
    rdata_o = rbuf_i;
    case (size_i)
      SZ_B:    rdata_o = {{56{~unsigned_i & rbuf_i[7]}},  rbuf_i[7:0]};
      SZ_H:    rdata_o = {{48{~unsigned_i & rbuf_i[15]}}, rbuf_i[15:0]};
      SZ_W:    rdata_o = {{32{~unsigned_i & rbuf_i[31]}}, rbuf_i[31:0]};
      default: rdata_o = rbuf_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Initiator for the 64-bit Data_Memory port: one request at a time, sized
// loads with extension, and read-modify-write for sub-dword stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES   = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input logic  clk,
  input logic  reset_n,
  lsu_if.slave bus
);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  size_e       size_q, size_d;
  logic        write_q, write_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] wdata_q, wdata_d;

  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_err;
  logic [63:0] load_data;
  logic [63:0] lane_mask;
  logic [63:0] merged;

  assign req_err = (bus.req_addr > 64'(MEM_BYTES - 8)) ||
                   (ALIGN_CHECK &&
                    ((bus.req_addr[3:0] & (size_bytes(bus.req_size) - 4'd1)) != 4'd0));

  // Read_Data is combinational, so it is used directly in the READ cycle as the read buffer.
  lsu_load_extend u_load_ext (
    .rbuf_i     (bus.Read_Data),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .rdata_o    (load_data)
  );

  lsu_load_extend u_mask_ext (
    .rbuf_i     (64'hFFFF_FFFF_FFFF_FFFF),
    .size_i     (size_q),
    .unsigned_i (1'b1),
    .rdata_o    (lane_mask)
  );

  assign merged = (wdata_q & lane_mask) | (bus.Read_Data & ~lane_mask);

  // Output registers are loaded from the next state, so each output is valid during its state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    write_d      = write_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    mem_addr_d   = 64'd0;
    wr_data_d    = 64'd0;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d     = bus.req_addr;
          size_d     = bus.req_size;
          write_d    = bus.req_write;
          unsigned_d = bus.req_unsigned;
          wdata_d    = bus.req_wdata;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 64'd0;
          end else if (!bus.req_write || (bus.req_size != SZ_D)) begin
            state_d    = READ;
            mem_read_d = 1'b1;
            mem_addr_d = bus.req_addr;
          end else begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_addr_d  = bus.req_addr;
            wr_data_d   = bus.req_wdata;
          end
        end
      end
      READ: begin
        if (write_q) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q;
          wr_data_d   = merged;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_data;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 64'd0;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 64'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= 64'd0;
      size_q       <= SZ_B;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      wdata_q      <= 64'd0;
      mem_addr_q   <= 64'd0;
      wr_data_q    <= 64'd0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      write_q      <= write_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      wr_data_q    <= wr_data_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Write_Data = wr_data_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.MemRead    = mem_read_q;

endmodule
